hdmi_line_reader: RTL and testbench



---
 rtl/hdmi_pkg.sv | 44 ++++
 rtl/hdmi_timing.sv | 73 +++++++
 rtl/hdmi_line_reader.sv | 239 +++++++++++++++++++++++
 tb/tb_hdmi_line_reader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// ----------------------------------------------------------------------------
// hdmi_pkg
// Shared constants and types for the HDMI line-buffer display path:
//   - default video timing (480x272 panel)
//   - line buffer geometry: two banks of up to 512 pixels, bank = raddr[9]
//   - pixel and counter widths
//   - fill request state type and a small window-decode helper
// ----------------------------------------------------------------------------
package hdmi_pkg;

    // Default timing
    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 64;
    localparam int DEF_H_BP     = 80;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 12;

    // Line buffer geometry
    localparam int BANK_BIT     = 9;
    localparam int LINE_PIX_MAX = 512;
    localparam int ADDR_W       = BANK_BIT + 1;

    // Data widths
    localparam int PIX_W        = 16;
    localparam int CNT_W        = 11;
    localparam int CNT_LIMIT    = 2048;

    // Fill request tracking: one request outstanding at most
    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_REQ  = 1'b1
    } fill_state_t;

    // True when lo <= cnt < hi
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input int unsigned      lo,
                                       input int unsigned      hi);
        return (cnt >= CNT_W'(lo)) && (cnt < CNT_W'(hi));
    endfunction

endpackage

// File: rtl/hdmi_timing.sv
// ----------------------------------------------------------------------------
// hdmi_timing
// Free-running horizontal/vertical video counters with active and sync decode.
// Counting starts on the first blanking line (v = V_ACTIVE) so a consumer has
// the whole vertical blanking interval to prepare line 0.
//
// Ports:
//   i_clk        pixel clock
//   i_rst_n      asynchronous active-low reset
//   o_h_cnt      horizontal position, 0..H_TOTAL-1
//   o_v_cnt      vertical position,   0..V_TOTAL-1
//   o_active     h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
//   o_hsync      hsync window decode (active-high, undelayed)
//   o_vsync      vsync window decode (active-high, undelayed)
//   o_line_start h_cnt == 0
// ----------------------------------------------------------------------------
module hdmi_timing
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_active,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    generate
        if (H_TOTAL >= CNT_LIMIT || V_TOTAL >= CNT_LIMIT) begin : g_bad_total
            $error("hdmi_timing: H_TOTAL and V_TOTAL must be below 2048");
        end
    endgenerate

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= CNT_W'(V_ACTIVE);
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    assign o_h_cnt      = r_h_cnt;
    assign o_v_cnt      = r_v_cnt;
    assign o_active     = (r_h_cnt < CNT_W'(H_ACTIVE)) && (r_v_cnt < CNT_W'(V_ACTIVE));
    assign o_hsync      = in_window(r_h_cnt, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
    assign o_vsync      = in_window(r_v_cnt, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    assign o_line_start = (r_h_cnt == '0);

endmodule

// File: rtl/hdmi_line_reader.sv
// ----------------------------------------------------------------------------
// hdmi_line_reader
// Display-side consumer of a ping-pong line buffer (1024x16, 1-cycle read).
// Line n lives in bank n[0]; while line n is shown, line n+1 is fetched into
// the other bank by an upstream fill engine.
//
// Ports:
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   buf_raddr  line buffer read address {bank, pixel index}
//   buf_rdata  line buffer read data, valid one cycle after buf_raddr
//   fill_req   fill request, held until fill_ack
//   fill_line  line number to fetch
//   fill_bank  destination bank
//   fill_ack   one-cycle pulse: requested line fully written
//   vid_hs     hsync, active-high
//   vid_vs     vsync, active-high
//   vid_de     data enable
//   vid_pix    pixel data (0 outside active or on a missing line)
//   underrun   sticky error: late fill or displayed an unfilled bank
//
// Fill handshake: fill_req acts as "valid" and fill_ack as a one-shot
// "done". While fill_req is high, fill_line/fill_bank hold steady; the
// request completes in the cycle fill_ack=1 and fill_req drops the cycle
// after, unless a new request is issued in that same cycle. An ack seen
// while fill_req is low is ignored.
//
// All video outputs are registered twice so they line up with the pixel
// returned by the buffer for the counter state two cycles earlier.
// ----------------------------------------------------------------------------
module hdmi_line_reader
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [PIX_W-1:0]  buf_rdata,
    output logic              fill_req,
    output logic [CNT_W-1:0]  fill_line,
    output logic              fill_bank,
    input  logic              fill_ack,
    output logic              vid_hs,
    output logic              vid_vs,
    output logic              vid_de,
    output logic [PIX_W-1:0]  vid_pix,
    output logic              underrun
);

    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_END_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_END_ACT  = CNT_W'(V_ACTIVE);

    generate
        if (H_ACTIVE > LINE_PIX_MAX) begin : g_bad_h_active
            $error("hdmi_line_reader: H_ACTIVE must not exceed 512");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Timing
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_active;
    logic             w_hsync;
    logic             w_vsync;
    logic             w_line_start;

    hdmi_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_h_cnt      (w_h_cnt),
        .o_v_cnt      (w_v_cnt),
        .o_active     (w_active),
        .o_hsync      (w_hsync),
        .o_vsync      (w_vsync),
        .o_line_start (w_line_start)
    );

    assign buf_raddr = {w_v_cnt[0], w_h_cnt[BANK_BIT-1:0]};

    // ------------------------------------------------------------------
    // Request instants: one line ahead, and line 0 on the last blank line
    // ------------------------------------------------------------------
    logic             w_req_now;
    logic [CNT_W-1:0] w_req_line;
    logic             w_req_bank;

    always_comb begin
        w_req_now  = 1'b0;
        w_req_line = '0;
        w_req_bank = 1'b0;
        if (w_line_start) begin
            if (w_v_cnt < V_LAST_ACT) begin
                w_req_now  = 1'b1;
                w_req_line = w_v_cnt + CNT_W'(1);
                w_req_bank = ~w_v_cnt[0];
            end else if (w_v_cnt == V_LAST) begin
                w_req_now  = 1'b1;
                w_req_line = '0;
                w_req_bank = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fill request FSM
    // ------------------------------------------------------------------
    fill_state_t      r_fill_state;
    fill_state_t      w_fill_state_next;
    logic [CNT_W-1:0] r_fill_line;
    logic             r_fill_bank;
    logic             w_ack;
    logic             w_collide;

    assign w_ack     = (r_fill_state == FILL_REQ) && fill_ack;
    // A new request while the previous one is still unacknowledged: the old
    // line is abandoned and the request is retargeted.
    assign w_collide = w_req_now && (r_fill_state == FILL_REQ) && !fill_ack;

    always_comb begin
        w_fill_state_next = r_fill_state;
        case (r_fill_state)
            FILL_IDLE: if (w_req_now)           w_fill_state_next = FILL_REQ;
            FILL_REQ:  if (w_ack && !w_req_now) w_fill_state_next = FILL_IDLE;
            default:                            w_fill_state_next = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_state <= FILL_IDLE;
            r_fill_line  <= '0;
            r_fill_bank  <= 1'b0;
        end else begin
            r_fill_state <= w_fill_state_next;
            if (w_req_now) begin
                r_fill_line <= w_req_line;
                r_fill_bank <= w_req_bank;
            end
        end
    end

    assign fill_req  = (r_fill_state == FILL_REQ);
    assign fill_line = r_fill_line;
    assign fill_bank = r_fill_bank;

    // ------------------------------------------------------------------
    // Bank validity. Set by ack; cleared when a bank becomes a fill target
    // and when its line has finished displaying. Clears win over the set.
    // ------------------------------------------------------------------
    logic [1:0] r_bank_valid;
    logic [1:0] w_bank_valid_next;
    logic       w_release;

    assign w_release = (w_h_cnt == H_END_ACT) && (w_v_cnt < V_END_ACT);

    always_comb begin
        w_bank_valid_next = r_bank_valid;
        if (w_ack)     w_bank_valid_next[r_fill_bank] = 1'b1;
        if (w_release) w_bank_valid_next[w_v_cnt[0]]  = 1'b0;
        if (w_req_now) w_bank_valid_next[w_req_bank]  = 1'b0;
    end

    // An ack arriving in this very cycle means the line is already complete,
    // so the pixel addressed now (data returned next cycle) is good.
    logic w_disp_bank_ok;
    logic w_disp_underrun;

    assign w_disp_bank_ok  = r_bank_valid[w_v_cnt[0]] | (w_ack && (r_fill_bank == w_v_cnt[0]));
    assign w_disp_underrun = w_active && !w_disp_bank_ok;

    // ------------------------------------------------------------------
    // Status and output pipeline
    // ------------------------------------------------------------------
    logic             r_underrun;
    logic             r_de_d1;
    logic             r_hs_d1;
    logic             r_vs_d1;
    logic             r_pix_ok_d1;
    logic             r_vid_de;
    logic             r_vid_hs;
    logic             r_vid_vs;
    logic [PIX_W-1:0] r_vid_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_valid <= 2'b00;
            r_underrun   <= 1'b0;
            r_de_d1      <= 1'b0;
            r_hs_d1      <= 1'b0;
            r_vs_d1      <= 1'b0;
            r_pix_ok_d1  <= 1'b0;
            r_vid_de     <= 1'b0;
            r_vid_hs     <= 1'b0;
            r_vid_vs     <= 1'b0;
            r_vid_pix    <= '0;
        end else begin
            r_bank_valid <= w_bank_valid_next;
            r_underrun   <= r_underrun | w_collide | w_disp_underrun;
            r_de_d1      <= w_active;
            r_hs_d1      <= w_hsync;
            r_vs_d1      <= w_vsync;
            r_pix_ok_d1  <= w_active && w_disp_bank_ok;
            r_vid_de     <= r_de_d1;
            r_vid_hs     <= r_hs_d1;
            r_vid_vs     <= r_vs_d1;
            r_vid_pix    <= r_pix_ok_d1 ? buf_rdata : '0;
        end
    end

    assign underrun = r_underrun;
    assign vid_de   = r_vid_de;
    assign vid_hs   = r_vid_hs;
    assign vid_vs   = r_vid_vs;
    assign vid_pix  = r_vid_pix;

endmodule

// File: tb/tb_hdmi_line_reader.sv
// ----------------------------------------------------------------------------
// tb_hdmi_line_reader
// Bench for hdmi_line_reader with a reduced raster (64x12 active, 120x18
// total) so several frames fit in a short run. The buffer model returns
// {bank, idx[8:0], 6'b0}; a fill responder acks each request ACK_DLY
// cycles after it appears, unless that line is being withheld.
// Position model: at a falling edge, with cyc edges since reset release, the
// counters sit at pos(cyc) and the video outputs show pos(cyc-2).
// ----------------------------------------------------------------------------
module tb_hdmi_line_reader;

    localparam int HA = 64;
    localparam int HF = 8;
    localparam int HS = 16;
    localparam int HB = 32;
    localparam int VA = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 120
    localparam int VT = VA + VF + VS + VB;   // 18
    localparam int FRAME = HT * VT;          // 2160
    localparam int ACK_DLY = 100;
    localparam int FIRST_REQ_CYC = (VT - 1 - VA) * HT + 1;  // 601
    localparam int LIMIT = 2 * FRAME;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0]  buf_raddr;
    logic [15:0] buf_rdata = '0;
    logic        fill_req;
    logic [10:0] fill_line;
    logic        fill_bank;
    logic        fill_ack;
    logic        vid_hs;
    logic        vid_vs;
    logic        vid_de;
    logic [15:0] vid_pix;
    logic        underrun;

    hdmi_line_reader #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .buf_raddr (buf_raddr),
        .buf_rdata (buf_rdata),
        .fill_req  (fill_req),
        .fill_line (fill_line),
        .fill_bank (fill_bank),
        .fill_ack  (fill_ack),
        .vid_hs    (vid_hs),
        .vid_vs    (vid_vs),
        .vid_de    (vid_de),
        .vid_pix   (vid_pix),
        .underrun  (underrun)
    );

    // ---------------- cycle counter ----------------
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int pos_h(input int c);
        return c % HT;
    endfunction

    function automatic int pos_v(input int c);
        return (VA + c / HT) % VT;
    endfunction

    // ---------------- buffer model ----------------
    always @(posedge clk) buf_rdata <= {buf_raddr, 6'b000000};

    // ---------------- fill responder ----------------
    logic        auto_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic        withhold_en = 1'b0;
    logic [10:0] withhold_line = '0;
    logic [10:0] seen_line = '0;
    int          age = 0;

    assign fill_ack = auto_ack | man_ack;

    always @(negedge clk) begin
        if (!rst_n || !fill_req) begin
            age      = 0;
            auto_ack = 1'b0;
        end else begin
            if (fill_line != seen_line) age = 0;
            else                        age = age + 1;
            auto_ack = (age == ACK_DLY) && !(withhold_en && fill_line == withhold_line);
        end
        seen_line = fill_line;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (at falling edges) until the outputs show position (h,v).
    task automatic goto_out(input int h, input int v, input string tag);
        int n = 0;
        while (!(cyc >= 2 && pos_h(cyc - 2) == h && pos_v(cyc - 2) == v) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({"reach_out_", tag}, (n >= LIMIT), 0);
    endtask

    // Wait (at falling edges) until the counters sit at position (h,v).
    task automatic goto_state(input int h, input int v, input string tag);
        int n = 0;
        while (!(pos_h(cyc) == h && pos_v(cyc) == v) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({"reach_state_", tag}, (n >= LIMIT), 0);
    endtask

    function automatic logic sig_now(input int sel);
        case (sel)
            0:       return vid_de;
            1:       return vid_hs;
            2:       return vid_vs;
            default: return fill_req;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic lvl, input string tag);
        int n = 0;
        while (sig_now(sel) !== lvl && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({"wait_", tag}, (n >= LIMIT), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_de"},        vid_de,    0);
        check({tag, "_hs"},        vid_hs,    0);
        check({tag, "_vs"},        vid_vs,    0);
        check({tag, "_pix"},       vid_pix,   0);
        check({tag, "_fill_req"},  fill_req,  0);
        check({tag, "_fill_line"}, fill_line, 0);
        check({tag, "_fill_bank"}, fill_bank, 0);
        check({tag, "_underrun"},  underrun,  0);
        check({tag, "_raddr"},     buf_raddr, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          h;
        int          v;
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] pix;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        int c1;
        int de_cnt;
        int de_err;
        int sync_err;
        int pix_err;

        vecs[0]  = '{1,   0,  1'b1, 1'b0, 1'b0, 16'h0040};
        vecs[1]  = '{7,   5,  1'b1, 1'b0, 1'b0, 16'h81C0};
        vecs[2]  = '{63,  5,  1'b1, 1'b0, 1'b0, 16'h8FC0};
        vecs[3]  = '{64,  5,  1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{71,  6,  1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{72,  6,  1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[6]  = '{87,  6,  1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[7]  = '{88,  6,  1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[8]  = '{0,   11, 1'b1, 1'b0, 1'b0, 16'h8000};
        vecs[9]  = '{0,   12, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[10] = '{5,   13, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{0,   14, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[12] = '{119, 15, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[13] = '{0,   16, 1'b0, 1'b0, 1'b0, 16'h0000};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;

        // First request: line 0 into bank 0, raised right after (0, V_TOTAL-1)
        wait_sig(3, 1'b1, "first_req");
        check("first_req_cyc",  cyc,       FIRST_REQ_CYC);
        check("first_req_line", fill_line, 0);
        check("first_req_bank", fill_bank, 0);

        // Whole first frame: de/sync/pixels against the position model
        goto_out(0, 0, "frame1");
        de_cnt = 0; de_err = 0; sync_err = 0; pix_err = 0;
        for (int k = 0; k < FRAME; k++) begin
            int h;
            int v;
            logic       e_de;
            logic [9:0] e_addr;
            h = pos_h(cyc - 2);
            v = pos_v(cyc - 2);
            e_de   = (h < HA) && (v < VA);
            e_addr = {v[0], h[8:0]};
            if (vid_de) de_cnt++;
            if (vid_de !== e_de) de_err++;
            if (vid_hs !== (h >= HA + HF && h < HA + HF + HS)) sync_err++;
            if (vid_vs !== (v >= VA + VF && v < VA + VF + VS)) sync_err++;
            if (vid_pix !== (e_de ? {e_addr, 6'b000000} : 16'h0000)) pix_err++;
            @(negedge clk);
        end
        check("frame1_de_count", de_cnt,   VA * HA);
        check("frame1_de_err",   de_err,   0);
        check("frame1_sync_err", sync_err, 0);
        check("frame1_pix_err",  pix_err,  0);
        check("frame1_underrun", underrun, 0);

        // Directed points in frame 2
        for (int i = 0; i < NVEC; i++) begin
            goto_out(vecs[i].h, vecs[i].v, $sformatf("v%0d", i));
            check($sformatf("vec%0d_de",  i), vid_de,  vecs[i].de);
            check($sformatf("vec%0d_hs",  i), vid_hs,  vecs[i].hs);
            check($sformatf("vec%0d_vs",  i), vid_vs,  vecs[i].vs);
            check($sformatf("vec%0d_pix", i), vid_pix, vecs[i].pix);
        end

        // Sync placement and width relative to de
        wait_sig(0, 1'b1, "de_rise");
        c0 = cyc;
        wait_sig(1, 1'b1, "hs_rise");
        check("hs_after_de", cyc - c0, HA + HF);
        c1 = cyc;
        wait_sig(1, 1'b0, "hs_fall");
        check("hs_width", cyc - c1, HS);
        wait_sig(2, 1'b1, "vs_rise");
        check("vs_start_line", pos_v(cyc - 2), VA + VF);
        check("vs_start_h",    pos_h(cyc - 2), 0);
        c1 = cyc;
        wait_sig(2, 1'b0, "vs_fall");
        check("vs_width", cyc - c1, VS * HT);

        // Ack coinciding with the next request instant (line 3 acked at (0,3))
        withhold_line = 11'd3;
        withhold_en   = 1'b1;
        goto_state(0, 3, "ack_coincide");
        check("coin_pending_req",  fill_req,  1);
        check("coin_pending_line", fill_line, 3);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        withhold_en = 1'b0;
        check("coin_next_req",  fill_req,  1);
        check("coin_next_line", fill_line, 4);
        check("coin_next_bank", fill_bank, 0);
        check("coin_underrun",  underrun,  0);
        goto_out(0, 3, "coin_pix0");
        check("coin_pix0", vid_pix, 16'h8000);
        goto_out(10, 3, "coin_pix10");
        check("coin_pix10",      vid_pix,  16'h8280);
        check("coin_underrun_2", underrun, 0);

        // Withheld ack for line 10: retarget to 11, line 10 blanked
        withhold_line = 11'd10;
        withhold_en   = 1'b1;
        goto_state(0, 10, "late_fill");
        check("late_pre_underrun", underrun,  0);
        check("late_pre_line",     fill_line, 10);
        @(negedge clk);
        withhold_en = 1'b0;
        check("late_underrun", underrun,  1);
        check("late_req",      fill_req,  1);
        check("late_line",     fill_line, 11);
        check("late_bank",     fill_bank, 1);
        goto_out(7, 10, "late_pix");
        check("late_de",  vid_de,  1);
        check("late_pix", vid_pix, 0);
        goto_out(7, 11, "next_pix");
        check("next_line_pix",   vid_pix,  16'h81C0);
        check("underrun_sticky", underrun, 1);

        // Reset in mid-line with a request outstanding
        goto_state(20, 1, "mid_reset");
        check("mid_pre_req",      fill_req, 1);
        check("mid_pre_underrun", underrun, 1);
        check("mid_pre_de",       vid_de,   1);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        check("stray_ack_req",   fill_req,          0);
        check("stray_ack_valid", dut.r_bank_valid,  0);
        check("stray_underrun",  underrun,          0);
        wait_sig(3, 1'b1, "restart_req");
        check("restart_req_cyc",  cyc,       FIRST_REQ_CYC);
        check("restart_req_line", fill_line, 0);
        check("restart_req_bank", fill_bank, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
